// File: rtl/nn_wmem_arbiter_pkg.sv
// Shared constants and types for the neural-net weight memory arbiter.
// Layer-1 weights live at L1_WADDR and layer-2 weights at L2_WADDR.
package nn_wmem_arbiter_pkg;

  localparam int unsigned WWIDTH        = 8;
  localparam int unsigned DATA_W        = 256;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned NUM_RD        = 2;
  localparam int unsigned MAX_WR_STREAK = 4;

  localparam logic [ADDR_W-1:0] L1_WADDR = 4'd0;
  localparam logic [ADDR_W-1:0] L2_WADDR = 4'd1;

  typedef enum logic [1:0] {
    GntNone,
    GntWr,
    GntRd
  } gnt_kind_e;

  // Index that follows idx in a ring of n entries.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/nn_wmem_arbiter_if.sv
// Bundle of host-write, engine-read and RAM-side signals around the weight memory arbiter.
// The slave modport is the arbiter view; master is the requester/RAM environment view.
interface nn_wmem_arbiter_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 2
);

  logic                       wr_req;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       wr_gnt;

  logic [NUM_RD-1:0]          rd_req;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0]          rd_gnt;
  logic [NUM_RD-1:0]          rd_rvalid;
  logic [DATA_W-1:0]          rd_rdata;

  logic [ADDR_W-1:0]          ram_a;
  logic [DATA_W-1:0]          ram_d;
  logic                       ram_we;
  logic [DATA_W-1:0]          ram_q;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    output wr_gnt, rd_gnt, rd_rvalid, rd_rdata, ram_a, ram_d, ram_we
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    input  wr_gnt, rd_gnt, rd_rvalid, rd_rdata, ram_a, ram_d, ram_we
  );

endinterface

// File: rtl/nn_wmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr_i, with wrap-around.
// Produces a one-hot grant, its index and a valid flag when any request is present.
module nn_rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[pos[IdxW-1:0]]) begin
        valid_o                = 1'b1;
        gnt_o[pos[IdxW-1:0]]   = 1'b1;
        idx_o                  = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/nn_wmem_arbiter.sv
// Single-port weight RAM arbiter: one host writer versus NUM_RD round-robin readers.
// The writer has priority but is held off after MAX_WR_STREAK grants while reads wait.
module nn_wmem_arbiter
  import nn_wmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W        = nn_wmem_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W        = nn_wmem_arbiter_pkg::ADDR_W,
  parameter int unsigned NUM_RD        = nn_wmem_arbiter_pkg::NUM_RD,
  parameter int unsigned MAX_WR_STREAK = nn_wmem_arbiter_pkg::MAX_WR_STREAK
) (
  input  logic                 clk,
  input  logic                 reset,
  nn_wmem_arbiter_if.slave     bus_if
);

  localparam int unsigned IdxW    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned StreakW = $clog2(MAX_WR_STREAK + 1);

  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [StreakW-1:0] wr_streak_q, wr_streak_d;
  logic [NUM_RD-1:0]  rvalid_q, rvalid_d;

  logic [NUM_RD-1:0]  pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;

  logic               any_rd;
  logic               streak_full;
  gnt_kind_e          gnt_kind;
  logic [NUM_RD-1:0]  rd_gnt;

  nn_rr_pick #(
    .N (NUM_RD)
  ) u_rr_pick (
    .req_i   (bus_if.rd_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign any_rd      = |bus_if.rd_req;
  assign streak_full = (wr_streak_q == StreakW'(MAX_WR_STREAK));

  // Grant decision: writer first unless the streak limit yields to a waiting reader.
  always_comb begin
    gnt_kind = GntNone;
    if (!reset) begin
      if (bus_if.wr_req && !(any_rd && streak_full)) begin
        gnt_kind = GntWr;
      end else if (pick_valid) begin
        gnt_kind = GntRd;
      end
    end
  end

  assign rd_gnt = (gnt_kind == GntRd) ? pick_gnt : '0;

  always_comb begin
    bus_if.wr_gnt = (gnt_kind == GntWr);
    bus_if.rd_gnt = rd_gnt;
    bus_if.ram_we = (gnt_kind == GntWr);
    bus_if.ram_d  = bus_if.wr_data;
    unique case (gnt_kind)
      GntWr:   bus_if.ram_a = bus_if.wr_addr;
      GntRd:   bus_if.ram_a = bus_if.rd_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
      default: bus_if.ram_a = '0;
    endcase
    // Gated so a read in flight when reset arrives never surfaces.
    bus_if.rd_rvalid = reset ? '0 : rvalid_q;
    bus_if.rd_rdata  = bus_if.ram_q;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_streak_d = wr_streak_q;
    rvalid_d    = rd_gnt;
    if (gnt_kind == GntRd) begin
      rr_ptr_d = IdxW'(rr_wrap(32'(pick_idx), NUM_RD));
    end
    if (gnt_kind == GntRd || !any_rd) begin
      wr_streak_d = '0;
    end else if (gnt_kind == GntWr && !streak_full) begin
      wr_streak_d = wr_streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      wr_streak_q <= '0;
      rvalid_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_streak_q <= wr_streak_d;
      rvalid_q    <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_nn_wmem_arbiter.sv
// Randomized and directed bench for nn_wmem_arbiter against a transaction-level model
// of the arbitration rules, with a behavioural one-cycle-latency RAM attached.
module tb_nn_wmem_arbiter;

  localparam int MAX = 4;

  logic clk;
  logic rst;

  nn_wmem_arbiter_if bus_if ();

  nn_wmem_arbiter dut (
    .clk    (clk),
    .reset  (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, write on ram_we.
  logic [255:0] mem [16];
  always @(posedge clk) begin
    if (bus_if.ram_we) mem[bus_if.ram_a] <= bus_if.ram_d;
    bus_if.ram_q <= mem[bus_if.ram_a];
  end

  // Requester state
  logic         wr_pend;
  logic [3:0]   wr_a;
  logic [255:0] wr_d;
  logic [1:0]   rd_pend;
  logic [3:0]   rd_a [2];

  // Reference model state
  int           m_ptr;
  int           m_streak;
  logic [1:0]   m_rvalid;
  logic [255:0] m_rdata;
  logic [255:0] shadow [16];

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r);
    logic       any_rd;
    logic       e_wr;
    logic [1:0] e_rd;
    logic [3:0] e_a;
    int         sel;
    @(negedge clk);
    rst            = r;
    bus_if.wr_req  = wr_pend;
    bus_if.wr_addr = wr_a;
    bus_if.wr_data = wr_d;
    bus_if.rd_req  = rd_pend;
    bus_if.rd_addr = {rd_a[1], rd_a[0]};
    #1;
    any_rd = |rd_pend;
    e_wr   = 1'b0;
    e_rd   = 2'b00;
    e_a    = 4'd0;
    sel    = -1;
    if (!r) begin
      if (wr_pend && !(any_rd && m_streak == MAX)) begin
        e_wr = 1'b1;
        e_a  = wr_a;
      end else if (any_rd) begin
        for (int k = 0; k < 2; k++) begin
          int p;
          p = (m_ptr + k) % 2;
          if (sel < 0 && rd_pend[p]) sel = p;
        end
        e_rd[sel] = 1'b1;
        e_a       = rd_a[sel];
      end
    end
    check_eq("wr_gnt", 256'(bus_if.wr_gnt), 256'(e_wr));
    check_eq("rd_gnt", 256'(bus_if.rd_gnt), 256'(e_rd));
    check_eq("ram_we", 256'(bus_if.ram_we), 256'(e_wr));
    if (!r) check_eq("ram_a", 256'(bus_if.ram_a), 256'(e_a));
    if (e_wr) check_eq("ram_d", bus_if.ram_d, wr_d);
    check_eq("rd_rvalid", 256'(bus_if.rd_rvalid), r ? 256'(0) : 256'(m_rvalid));
    if (!r && m_rvalid != 2'b00) check_eq("rd_rdata", bus_if.rd_rdata, m_rdata);
    @(posedge clk);
    if (r) begin
      m_ptr    = 0;
      m_streak = 0;
      m_rvalid = 2'b00;
    end else begin
      if (e_wr) shadow[wr_a] = wr_d;
      m_rvalid = e_rd;
      if (sel >= 0) begin
        m_rdata = shadow[rd_a[sel]];
        m_ptr   = (sel + 1) % 2;
      end
      if (sel >= 0 || !any_rd) m_streak = 0;
      else if (e_wr && m_streak < MAX) m_streak++;
    end
    if (e_wr) wr_pend = 1'b0;
    if (sel >= 0) rd_pend[sel] = 1'b0;
  endtask

  int wr_pct [4] = '{90, 50, 10, 100};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    m_streak = 0;
    m_rvalid = 2'b00;
    m_rdata  = '0;
    rst      = 1'b1;
    wr_pend  = 1'b1;
    wr_a     = 4'd0;
    wr_d     = {8{$urandom}};
    rd_pend  = 2'b11;
    rd_a[0]  = 4'd2;
    rd_a[1]  = 4'd3;

    // Reset held with every requester active, then the writer takes the first cycle.
    repeat (3) step(1'b1);
    step(1'b0);

    // Fill the RAM through the arbiter so model and RAM agree.
    rd_pend = 2'b00;
    for (int a = 0; a < 16; a++) begin
      wr_pend = 1'b1;
      wr_a    = 4'(a);
      wr_d    = (a == 1) ? {32{8'hA5}} : {$urandom, $urandom, $urandom, $urandom,
                                          $urandom, $urandom, $urandom, $urandom};
      step(1'b0);
    end

    // Single reader fetches the layer-2 word.
    rd_pend = 2'b01;
    rd_a[0] = 4'd1;
    step(1'b0);
    step(1'b0);
    check_eq("t2_rdata", bus_if.rd_rdata, {32{8'hA5}});

    // Both readers held: alternating grants.
    for (int i = 0; i < 8; i++) begin
      rd_pend = 2'b11;
      step(1'b0);
    end
    rd_pend = 2'b00;
    step(1'b0);

    // Writer and reader 1 held: write streak limit applies.
    rd_a[1] = 4'd5;
    for (int i = 0; i < 15; i++) begin
      if (!wr_pend) begin
        wr_pend = 1'b1;
        wr_a    = 4'(8 + (i % 4));
        wr_d    = {8{$urandom}};
      end
      rd_pend[1] = 1'b1;
      step(1'b0);
    end
    wr_pend = 1'b0;
    rd_pend = 2'b00;
    step(1'b0);

    // Write-then-read of the same address returns the new word.
    wr_pend = 1'b1;
    wr_a    = 4'd0;
    wr_d    = {16{16'h1234}};
    step(1'b0);
    rd_pend = 2'b01;
    rd_a[0] = 4'd0;
    step(1'b0);
    step(1'b0);
    check_eq("t5_rdata", bus_if.rd_rdata, {16{16'h1234}});

    // Reset right after a reader-1 grant suppresses its rvalid and rewinds the pointer.
    rd_pend = 2'b10;
    rd_a[1] = 4'd1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    rd_pend = 2'b11;
    step(1'b0);
    rd_pend = 2'b00;
    step(1'b0);

    // Randomized traffic at several write intensities.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 400; c++) begin
        if (!wr_pend && $urandom_range(99) < wr_pct[ph]) begin
          wr_pend = 1'b1;
          wr_a    = 4'($urandom_range(15));
          wr_d    = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        end
        for (int i = 0; i < 2; i++) begin
          if (!rd_pend[i] && $urandom_range(99) < 40) begin
            rd_pend[i] = 1'b1;
            rd_a[i]    = 4'($urandom_range(15));
          end else if (rd_pend[i] && $urandom_range(99) < 3) begin
            rd_pend[i] = 1'b0;
          end
        end
        step(($urandom_range(199) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
